// File: rtl/amber128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amber128_pkg
// Description : Shared Amber128 types and constants. Holds the fetch bundle
//               struct, the sequencer state enum and the two-12 flag lookup
//               used by both the decoder and the slot sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package amber128_pkg;

    localparam int C_NUM_SLOTS   = 5;
    localparam int C_FLAGS_HI    = 127;
    localparam int C_FLAGS_LO    = 123;
    localparam int C_WORD_ADDR_W = 32;

    typedef struct packed {
        logic                     valid;
        logic [C_WORD_ADDR_W-1:0] word_addr;
        logic [127:0]             bundle;
    } amber128_fetch_s;

    typedef enum logic [0:0] {
        SEQ_EMPTY = 1'b0,
        SEQ_HOLD  = 1'b1
    } seq_state_e;

    // Slot 0 owns the MSB of the flag field, slot 4 the LSB.
    function automatic logic slot_is_two12(input logic [C_NUM_SLOTS-1:0] flags,
                                           input logic [2:0]             idx);
        logic [2:0] bit_pos;
        bit_pos = 3'(C_NUM_SLOTS - 1) - idx;
        return flags[bit_pos];
    endfunction

endpackage
`default_nettype wire

// File: rtl/amber128_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : amber128_slot_sequencer
// Description : Holds one 128-bit bundle from fetch and issues its
//               instructions in program order (slot 0..4, sub 0/1 for two-12
//               slots) to the decoder over a valid/ready handshake. Refills
//               back-to-back on the last issue; flush drops the held bundle.
// Ports       : clk_i, rst_i (async, active-high)
//               fetch_i / fetch_ready_o        - bundle input handshake
//               flush_i                        - discard held bundle
//               fetch_o, slot_idx_o, sub12_o   - presented instruction
//               issue_valid_o / issue_ready_i  - issue handshake
//               last_o                         - final instruction of bundle
//               perf_bundles_o, perf_instrs_o  - counters, live only when
//                                                AMBER128_SEQ_PERF_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module amber128_slot_sequencer
    import amber128_pkg::*;
#(
    parameter int NUM_SLOTS  = 5,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  amber128_fetch_s       fetch_i,
    output logic                  fetch_ready_o,
    input  logic                  flush_i,
    output amber128_fetch_s       fetch_o,
    output logic [2:0]            slot_idx_o,
    output logic                  sub12_o,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    output logic                  last_o,
    output logic [PERF_CNT_W-1:0] perf_bundles_o,
    output logic [PERF_CNT_W-1:0] perf_instrs_o
);

    // The slot walk and flag indexing are hard-wired to the 5-slot ISA.
    if (NUM_SLOTS != C_NUM_SLOTS) begin : g_num_slots_check
        $error("amber128_slot_sequencer: NUM_SLOTS must be 5");
    end

    seq_state_e      r_state;
    seq_state_e      w_state_nxt;
    amber128_fetch_s r_bundle;
    amber128_fetch_s w_bundle_nxt;
    logic [2:0]      r_slot;
    logic [2:0]      w_slot_nxt;
    logic            r_sub;
    logic            w_sub_nxt;

    logic [C_NUM_SLOTS-1:0] w_flags;
    logic                   w_two12;
    logic                   w_hold;
    logic                   w_fire;
    logic                   w_accept;

    assign w_flags = r_bundle.bundle[C_FLAGS_HI:C_FLAGS_LO];
    assign w_two12 = slot_is_two12(w_flags, r_slot);
    assign w_hold  = (r_state == SEQ_HOLD);

    assign issue_valid_o = w_hold & ~flush_i;
    assign slot_idx_o    = r_slot;
    assign sub12_o       = r_sub;
    assign last_o        = w_hold & (r_slot == 3'(C_NUM_SLOTS - 1)) & (~w_two12 | r_sub);
    assign w_fire        = issue_valid_o & issue_ready_i;

    // Ready also during the last fire so the next bundle lands with no bubble.
    // Held low while in reset so every output reads zero until release.
    assign fetch_ready_o = ~rst_i & ~flush_i & (~w_hold | (w_fire & last_o));
    assign w_accept      = fetch_i.valid & fetch_ready_o;

    always_comb begin
        fetch_o       = r_bundle;
        fetch_o.valid = issue_valid_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= SEQ_EMPTY;
            r_bundle <= '0;
            r_slot   <= '0;
            r_sub    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bundle <= w_bundle_nxt;
            r_slot   <= w_slot_nxt;
            r_sub    <= w_sub_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bundle_nxt = r_bundle;
        w_slot_nxt   = r_slot;
        w_sub_nxt    = r_sub;
        if (flush_i) begin
            w_state_nxt = SEQ_EMPTY;
            w_slot_nxt  = '0;
            w_sub_nxt   = 1'b0;
        end else if (w_accept) begin
            // Covers both the empty case and refill on the last fire.
            w_state_nxt  = SEQ_HOLD;
            w_bundle_nxt = fetch_i;
            w_slot_nxt   = '0;
            w_sub_nxt    = 1'b0;
        end else if (w_fire) begin
            if (last_o) begin
                w_state_nxt = SEQ_EMPTY;
                w_slot_nxt  = '0;
                w_sub_nxt   = 1'b0;
            end else if (w_two12 && !r_sub) begin
                w_sub_nxt = 1'b1;
            end else begin
                w_sub_nxt  = 1'b0;
                w_slot_nxt = r_slot + 3'd1;
            end
        end
    end

`ifdef AMBER128_SEQ_PERF_EN
    logic [PERF_CNT_W-1:0] r_perf_bundles;
    logic [PERF_CNT_W-1:0] r_perf_instrs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_bundles <= '0;
            r_perf_instrs  <= '0;
        end else begin
            if (w_fire) begin
                r_perf_instrs <= r_perf_instrs + 1'b1;
            end
            if (w_fire && last_o) begin
                r_perf_bundles <= r_perf_bundles + 1'b1;
            end
        end
    end

    assign perf_bundles_o = r_perf_bundles;
    assign perf_instrs_o  = r_perf_instrs;
`else
    assign perf_bundles_o = '0;
    assign perf_instrs_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_amber128_slot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_amber128_slot_sequencer
// Description : Self-checking bench for amber128_slot_sequencer. A reference
//               model expands each accepted bundle into its list of expected
//               (slot, sub, last) issues and compares the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amber128_slot_sequencer;
    import amber128_pkg::*;

    localparam int C_PERF_W = 32;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    amber128_fetch_s     fetch_i = '0;
    logic                fetch_ready_o;
    logic                flush_i = 1'b0;
    amber128_fetch_s     fetch_o;
    logic [2:0]          slot_idx_o;
    logic                sub12_o;
    logic                issue_valid_o;
    logic                issue_ready_i = 1'b0;
    logic                last_o;
    logic [C_PERF_W-1:0] perf_bundles_o;
    logic [C_PERF_W-1:0] perf_instrs_o;

    amber128_slot_sequencer #(.NUM_SLOTS(5), .PERF_CNT_W(C_PERF_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fetch_i        (fetch_i),
        .fetch_ready_o  (fetch_ready_o),
        .flush_i        (flush_i),
        .fetch_o        (fetch_o),
        .slot_idx_o     (slot_idx_o),
        .sub12_o        (sub12_o),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .last_o         (last_o),
        .perf_bundles_o (perf_bundles_o),
        .perf_instrs_o  (perf_instrs_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] slot;
        logic       sub;
        logic       last;
    } issue_t;

    int          n_checks = 0;
    int          n_errors = 0;
    issue_t      m_q[$];
    logic [127:0] m_bundle = '0;
    logic [31:0]  m_addr   = '0;
    int unsigned  m_instrs  = 0;
    int unsigned  m_bundles = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue order derived from the bundle's flag field: every slot issues
    // once, flagged slots issue a second (sub=1) instruction.
    task automatic model_load(input logic [127:0] b, input logic [31:0] a);
        issue_t it;
        logic [4:0] fl;
        fl = b[127:123];
        m_q.delete();
        for (int s = 0; s < 5; s++) begin
            it.slot = 3'(s); it.sub = 1'b0; it.last = 1'b0;
            m_q.push_back(it);
            if (fl[4-s]) begin
                it.sub = 1'b1;
                m_q.push_back(it);
            end
        end
        m_q[m_q.size()-1].last = 1'b1;
        m_bundle = b;
        m_addr   = a;
    endtask

    task automatic check_perf(input string tag);
`ifdef AMBER128_SEQ_PERF_EN
        chk({tag, "_perf_instrs"},  192'(perf_instrs_o),  192'(m_instrs));
        chk({tag, "_perf_bundles"}, 192'(perf_bundles_o), 192'(m_bundles));
`else
        chk({tag, "_perf_instrs_tied"},  192'(perf_instrs_o),  192'(0));
        chk({tag, "_perf_bundles_tied"}, 192'(perf_bundles_o), 192'(0));
`endif
    endtask

    // One clock cycle: drive at negedge, compare, clock, advance model.
    task automatic cycle(input logic fv, input logic [4:0] flags, input logic fl,
                         input logic rdy, output logic acc);
        logic        hold, e_valid, e_last, e_fire, e_fr;
        logic [2:0]  e_slot;
        logic        e_sub;
        logic [127:0] nb;
        logic [31:0]  na;
        nb = {flags, 123'({$urandom, $urandom, $urandom, $urandom})};
        na = $urandom;
        fetch_i.valid     = fv;
        fetch_i.word_addr = na;
        fetch_i.bundle    = nb;
        flush_i           = fl;
        issue_ready_i     = rdy;
        #1;
        hold    = (m_q.size() > 0);
        e_valid = hold && !fl;
        e_slot  = hold ? m_q[0].slot : 3'd0;
        e_sub   = hold ? m_q[0].sub  : 1'b0;
        e_last  = hold ? m_q[0].last : 1'b0;
        e_fire  = e_valid && rdy;
        e_fr    = !fl && (!hold || (e_fire && e_last));
        chk("issue_valid", 192'(issue_valid_o), 192'(e_valid));
        chk("fetch_o_valid", 192'(fetch_o.valid), 192'(e_valid));
        chk("slot_idx", 192'(slot_idx_o), 192'(e_slot));
        chk("sub12", 192'(sub12_o), 192'(e_sub));
        chk("last", 192'(last_o), 192'(e_last));
        chk("fetch_ready", 192'(fetch_ready_o), 192'(e_fr));
        if (e_valid) begin
            chk("fetch_o_bundle", 192'(fetch_o.bundle), 192'(m_bundle));
            chk("fetch_o_addr", 192'(fetch_o.word_addr), 192'(m_addr));
        end
        check_perf("cyc");
        acc = fv && e_fr;
        @(posedge clk_i);
        if (fl) begin
            m_q.delete();
        end else begin
            if (e_fire) begin
                m_instrs++;
                if (e_last) m_bundles++;
                void'(m_q.pop_front());
            end
            if (acc) model_load(nb, na);
        end
        @(negedge clk_i);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int   n;
        n = 0;
        while (m_q.size() > 0 && n < 40) begin
            cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
            n++;
        end
        chk({tag, "_drained"}, 192'(m_q.size()), 192'(0));
    endtask

    // Present one bundle until accepted, bounded.
    task automatic load(input string tag, input logic [4:0] flags, input logic rdy);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 40) begin
            cycle(1'b1, flags, 1'b0, rdy, acc);
            n++;
        end
        chk({tag, "_accepted"}, 192'(acc), 192'(1));
    endtask

    initial begin
        logic acc;

        // Reset
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_issue_valid", 192'(issue_valid_o), 192'(0));
        chk("rst_slot", 192'(slot_idx_o), 192'(0));
        chk("rst_sub", 192'(sub12_o), 192'(0));
        chk("rst_last", 192'(last_o), 192'(0));
        chk("rst_fetch_o", 192'(fetch_o), 192'(0));
        chk("rst_fetch_ready", 192'(fetch_ready_o), 192'(1));
        check_perf("rst");
        @(negedge clk_i);

        // Flags 00000: five single issues, then empty
        load("s1", 5'b00000, 1'b1);
        drain("s1");
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);

        // Flags 10001: seven issues
        load("s2", 5'b10001, 1'b1);
        drain("s2");
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
`ifdef AMBER128_SEQ_PERF_EN
        chk("perf_instrs_s12", 192'(perf_instrs_o), 192'(12));
        chk("perf_bundles_s12", 192'(perf_bundles_o), 192'(2));
`endif

        // Back-to-back: 11111 then 00000 with fetch valid held
        load("s3a", 5'b11111, 1'b1);
        load("s3b", 5'b00000, 1'b1);
        drain("s3");

        // Stall three cycles at (2,0)
        load("s4", 5'b00000, 1'b1);
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
        chk("stall_at_slot2", 192'(slot_idx_o), 192'(2));
        repeat (3) cycle(1'b0, 5'd0, 1'b0, 1'b0, acc);
        drain("s4");

        // Flush at (1,1) with a new bundle offered
        load("s5", 5'b01000, 1'b1);
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
        chk("flush_at_sub1", 192'({slot_idx_o, sub12_o}), 192'({3'd1, 1'b1}));
        cycle(1'b1, 5'b00100, 1'b1, 1'b1, acc);
        chk("flush_no_accept", 192'(acc), 192'(0));
        cycle(1'b1, 5'b00100, 1'b0, 1'b1, acc);
        chk("after_flush_accept", 192'(acc), 192'(1));
        drain("s5");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), acc);
        end

        // Asynchronous reset mid-bundle
        load("s6", 5'b10101, 1'b1);
        cycle(1'b0, 5'd0, 1'b0, 1'b1, acc);
        rst_i = 1'b1;
        #1;
        m_q.delete();
        m_instrs  = 0;
        m_bundles = 0;
        chk("midrst_issue_valid", 192'(issue_valid_o), 192'(0));
        chk("midrst_slot", 192'(slot_idx_o), 192'(0));
        chk("midrst_sub", 192'(sub12_o), 192'(0));
        chk("midrst_last", 192'(last_o), 192'(0));
        check_perf("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("midrst_fetch_ready", 192'(fetch_ready_o), 192'(1));
        @(negedge clk_i);
        load("s7", 5'b00011, 1'b1);
        drain("s7");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/amber128_slot_sequencer.md
Name: amber128_slot_sequencer

Overview:
Issue-side sequencer between the fetch unit and `amber128_decoder`. It accepts one 128-bit bundle from fetch and holds it. It then walks the bundle in program order (slot 0..4, and sub-instruction 0/1 for slots flagged as two-12-bit). For each instruction it presents the held bundle, `slot_idx` and `sub12` to the decoder under a valid/ready handshake. It refills from fetch without a bubble and drops the held bundle on a pipeline flush.

Parameters:
- `NUM_SLOTS`, 5: slots per bundle. Fixed by the ISA; the RTL asserts it equals 5.
- `PERF_CNT_W`, 32: width of the performance counters (optional feature only).

Ports:
- `clk_i`  in  1  core clock
- `rst_i`  in  1  asynchronous reset, active-high
- `fetch_i`  in  `amber128_fetch_s`  bundle from fetch (`valid`, `word_addr`, `bundle[127:0]`)
- `fetch_ready_o`  out  1  sequencer accepts `fetch_i` this cycle
- `flush_i`  in  1  redirect/flush from branch resolution; discard held bundle
- `fetch_o`  out  `amber128_fetch_s`  held bundle to decoder; `.valid` equals `issue_valid_o`
- `slot_idx_o`  out  3  current slot, 0..4
- `sub12_o`  out  1  current sub-instruction of a two-12 slot
- `issue_valid_o`  out  1  an instruction is presented
- `issue_ready_i`  in  1  downstream consumes the presented instruction
- `last_o`  out  1  presented instruction is the final one of the bundle
- `perf_bundles_o`  out  `PERF_CNT_W`  bundles fully issued (optional feature only)
- `perf_instrs_o`  out  `PERF_CNT_W`  instructions issued (optional feature only)

Behaviour:
- **State:** `EMPTY` / `HOLD`, plus registers `bundle_q` (fetch struct), `slot_q[2:0]`, `sub_q`.
- **Reset** (asynchronous on `rst_i`): state `EMPTY`, `slot_q` = 0, `sub_q` = 0, `bundle_q` = '0. All outputs low/zero; `fetch_ready_o` = 1 after reset release.
- **Flags:** `flags` = `bundle_q.bundle[127:123]`. The two-12 flag for the current slot is `flags[4-slot_q]`, computed locally; the decoder's `slot_has_two12_o` is never used. Bits [122:120] are ignored.
- **Issue signals:**
  - `issue_valid_o` = (state == `HOLD`) & !`flush_i`.
  - `slot_idx_o` = `slot_q`; `sub12_o` = `sub_q`.
  - `fetch_o` = `bundle_q` with `.valid` overridden.
  - All combinational from registers, except the `flush_i` gating.
- **Last instruction:** `last_o` = `HOLD` & (`slot_q` == 4) & (!two12 | `sub_q`).
- **Issue handshake** (`fire` = `issue_valid_o` & `issue_ready_i`):
  - two12 & !`sub_q` → `sub_q` = 1.
  - Otherwise `sub_q` = 0 and `slot_q` + 1.
  - `fire` & `last_o` → bundle done.
- **Refill:**
  - `fetch_ready_o` = !`flush_i` & (`EMPTY` | (`fire` & `last_o`)).
  - `fetch_i.valid` & `fetch_ready_o` → latch `bundle_q`, `slot_q` = 0, `sub_q` = 0, state `HOLD`. This is back-to-back refill: no bubble between bundles.
  - Bundle done with no new fetch → `EMPTY`.
- **Stall:** `issue_ready_i` low holds `slot_q`, `sub_q`, `bundle_q` and all outputs stable. Valid is never dropped without a fire, except on flush.
- **Flush:** `flush_i` has highest priority.
  - Next state `EMPTY`, `slot_q` and `sub_q` cleared.
  - `fetch_i` is ignored that cycle; no fire counts.
  - Refill resumes the following cycle.
- **Instruction count:** 5 + popcount(`flags`) instructions per bundle, range 5..10.
- **Invariants:** `slot_q` never exceeds 4. `sub_q` = 1 only in a two-12 slot.

Optional Feature:
- Macro: `AMBER128_SEQ_PERF_EN`.
- **Defined:** two `PERF_CNT_W` counters, reset to 0 asynchronously.
  - `perf_instrs_o` += 1 per `fire`.
  - `perf_bundles_o` += 1 per `fire` & `last_o`.
  - Both wrap modulo 2^`PERF_CNT_W`; flush does not clear them.
- **Undefined:** both ports are tied to 0 and no counter flops exist. The port list is unchanged.

Decomposition:
- **Into `amber128_pkg`:**
  - `C_NUM_SLOTS` = 5.
  - `C_FLAGS_HI` = 127 and `C_FLAGS_LO` = 123.
  - Enum `seq_state_e` {`SEQ_EMPTY`, `SEQ_HOLD`}.
  - Reuse of `amber128_fetch_s`.
- **Sub-module:** none needed; counters stay inline under the macro.
- **Decoder sharing:** the shared function `slot_is_two12(flags, idx)` goes in the package so the decoder and sequencer agree on flag indexing.

Test Plan:
- **Flags 5'b00000**, `issue_ready_i` = 1 → (slot, sub) = (0,0),(1,0),(2,0),(3,0),(4,0) on 5 consecutive cycles. `last_o` only on slot 4, then `EMPTY`, `fetch_ready_o` = 1.
- **Flags 5'b10001** → sequence (0,0),(0,1),(1,0),(2,0),(3,0),(4,0),(4,1). 7 issues; `last_o` only at (4,1).
- **Two bundles** held valid back-to-back, flags 5'b11111 then 0 → 10 then 5 issues. `fetch_ready_o` high exactly in the last-fire cycle; no idle cycle between bundles.
- **Stall:** `issue_ready_i` = 0 for 3 cycles at (2,0) → outputs stable; resumes at (3,0).
- **Flush** asserted at (1,1) with `fetch_i.valid` = 1 → `issue_valid_o` = 0 and fetch not accepted that cycle. Next cycle the new bundle is accepted, slot 0.
- **Perf** with `AMBER128_SEQ_PERF_EN`: scenarios 1+2 → `perf_instrs_o` = 12, `perf_bundles_o` = 2. Reset mid-bundle → all zero, `EMPTY`.
